// File: rtl/rupd_pkg.sv
// Shared definitions for the remote-update sequencer: bus addresses, command codes,
// status word field positions and the sequencer state encoding.
package rupd_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;

  localparam logic [7:0] CTRL_NONE  = 8'h00;
  localparam logic [7:0] CTRL_RD    = 8'h01;
  localparam logic [7:0] CTRL_WR    = 8'h02;
  localparam logic [7:0] CTRL_WDOG  = 8'h04;
  localparam logic [7:0] CTRL_RECFG = 8'h80;

  localparam logic [2:0] P_TRIG = 3'd0;
  localparam logic [2:0] P_ADDR = 3'd4;
  localparam logic [2:0] P_IMG  = 3'd5;

  localparam logic [11:0] S0_DATA = 12'h004;
  localparam logic [11:0] S2_DATA = 12'h001;

  localparam int ST_BUSY_BIT = 31;
  localparam int ST_CTRL_MSB = 23;
  localparam int ST_CTRL_LSB = 16;
  localparam int ST_DATA_MSB = 11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_CTRL,
    S_WAIT_CLR,
    S_SETTLE,
    S_WAIT_BUSY,
    S_WR_RECFG,
    S_CAPTURE,
    S_DONE,
    S_FAIL
  } seq_state_e;

  function automatic logic [31:0] param_word(input logic [2:0] param, input logic [11:0] data);
    return {13'h0, param, 4'h0, data};
  endfunction

  function automatic logic [31:0] ctrl_word(input logic [7:0] code);
    return {24'h0, code};
  endfunction

endpackage

// File: rtl/rupd_bus_master.sv
// Register-bus strobe generator: turns a held write request into a single 1-cycle write
// strobe with ack, and drives the read strobes while the sequencer is polling.
module rupd_bus_master
  import rupd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        poll,
  output logic        wr_ack,
  output logic [1:0]  USER_ADDR,
  output logic [31:0] USER_DATA_OUT,
  output logic        USER_CEb,
  output logic        USER_WEb,
  output logic        USER_REb,
  output logic        USER_OEb
);

  logic        wr_active_q, wr_active_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;

  // The request is held until ack, so a strobe is never issued in the ack cycle itself.
  always_comb begin
    wr_active_d = wr_req & ~wr_active_q;
    addr_d      = wr_active_d ? wr_addr : ADDR_DATA;
    data_d      = wr_active_d ? wr_data : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_active_q <= 1'b0;
      addr_q      <= ADDR_DATA;
      data_q      <= 32'h0;
    end else begin
      wr_active_q <= wr_active_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign wr_ack        = wr_active_q;
  assign USER_ADDR     = addr_q;
  assign USER_DATA_OUT = data_q;
  assign USER_CEb      = ~(wr_active_q | poll);
  assign USER_WEb      = ~wr_active_q;
  assign USER_REb      = ~(poll & ~wr_active_q);
  assign USER_OEb      = ~(poll & ~wr_active_q);

endmodule

// File: rtl/rupd_sequencer.sv
// Remote-update sequencer: runs the three-step factory->application reconfigure or a
// config readback on the register bus, polling status with a per-step timeout.
module rupd_sequencer
  import rupd_pkg::*;
#(
  parameter int TIMEOUT_W     = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        RESETb,
  input  logic        START,
  input  logic        RD_REQ,
  input  logic [6:0]  PGM,
  output logic [1:0]  USER_ADDR,
  output logic [31:0] USER_DATA_OUT,
  input  logic [31:0] USER_DATA_IN,
  output logic        USER_CEb,
  output logic        USER_WEb,
  output logic        USER_REb,
  output logic        USER_OEb,
  output logic        SEQ_BUSY,
  output logic        SEQ_DONE,
  output logic        SEQ_ERROR,
  output logic [11:0] CUR_CONFIG
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST    = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  seq_state_e           state_q, state_d;
  logic [1:0]           step_q, step_d;
  logic                 rd_mode_q, rd_mode_d;
  logic [6:0]           pgm_q, pgm_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic                 err_q, err_d;
  logic [11:0]          cfg_q, cfg_d;

  logic        wr_req, wr_ack, poll, tmo_hit, st_busy, st_ctrl_clear;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data, step_word;
  logic        status_unused;

  assign st_busy       = USER_DATA_IN[ST_BUSY_BIT];
  assign st_ctrl_clear = (USER_DATA_IN[ST_CTRL_MSB:ST_CTRL_LSB] == 8'h00);
  assign status_unused = ^{USER_DATA_IN[30:24], USER_DATA_IN[15:12]};
  // Terminal count is 2**TIMEOUT_W-1 wait cycles; the counter starts at 0 in the first wait cycle.
  assign tmo_hit       = (tmo_q == TMO_LAST);

  always_comb begin
    step_word = param_word(P_IMG, S2_DATA);
    if (rd_mode_q) begin
      step_word = param_word(P_IMG, 12'h000);
    end else begin
      case (step_q)
        2'd0:    step_word = param_word(P_TRIG, S0_DATA);
        2'd1:    step_word = param_word(P_ADDR, {5'h0, pgm_q});
        default: step_word = param_word(P_IMG, S2_DATA);
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    rd_mode_d = rd_mode_q;
    pgm_d     = pgm_q;
    tmo_d     = tmo_q;
    settle_d  = settle_q;
    err_d     = err_q;
    cfg_d     = cfg_q;
    wr_req    = 1'b0;
    wr_addr   = ADDR_DATA;
    wr_data   = 32'h0;
    poll      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d   = S_WR_DATA;
          rd_mode_d = 1'b0;
          step_d    = 2'd0;
          pgm_d     = PGM;
          err_d     = 1'b0;
        end else if (RD_REQ) begin
          state_d   = S_WR_DATA;
          rd_mode_d = 1'b1;
          step_d    = 2'd0;
          err_d     = 1'b0;
        end
      end
      S_WR_DATA: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_DATA;
        wr_data = step_word;
        if (wr_ack) state_d = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_CTRL;
        wr_data = ctrl_word(rd_mode_q ? CTRL_RD : CTRL_WR);
        tmo_d   = '0;
        if (wr_ack) state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        poll     = 1'b1;
        settle_d = '0;
        if (tmo_hit) begin
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (st_ctrl_clear) state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        poll = 1'b1;
        if (tmo_hit) begin
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (settle_q == SETTLE_LAST) state_d = S_WAIT_BUSY;
          else                         settle_d = settle_q + 1'b1;
        end
      end
      S_WAIT_BUSY: begin
        poll = 1'b1;
        if (tmo_hit) begin
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (!st_busy) begin
            if (rd_mode_q)          state_d = S_CAPTURE;
            else if (step_q == 2'd2) state_d = S_WR_RECFG;
            else begin
              step_d  = step_q + 1'b1;
              state_d = S_WR_DATA;
            end
          end
        end
      end
      S_WR_RECFG: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_CTRL;
        wr_data = ctrl_word(CTRL_RECFG);
        if (wr_ack) state_d = S_DONE;
      end
      S_CAPTURE: begin
        poll    = 1'b1;
        cfg_d   = USER_DATA_IN[ST_DATA_MSB:0];
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      S_FAIL: begin
        // Cancel whatever command the interface may still be holding.
        wr_req  = 1'b1;
        wr_addr = ADDR_CTRL;
        wr_data = ctrl_word(CTRL_NONE);
        if (wr_ack) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      state_q   <= S_IDLE;
      step_q    <= 2'd0;
      rd_mode_q <= 1'b0;
      pgm_q     <= 7'h0;
      tmo_q     <= '0;
      settle_q  <= '0;
      err_q     <= 1'b0;
      cfg_q     <= 12'h0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      rd_mode_q <= rd_mode_d;
      pgm_q     <= pgm_d;
      tmo_q     <= tmo_d;
      settle_q  <= settle_d;
      err_q     <= err_d;
      cfg_q     <= cfg_d;
    end
  end

  rupd_bus_master u_bus (
    .clk           (CLK),
    .rst_n         (RESETb),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .poll          (poll),
    .wr_ack        (wr_ack),
    .USER_ADDR     (USER_ADDR),
    .USER_DATA_OUT (USER_DATA_OUT),
    .USER_CEb      (USER_CEb),
    .USER_WEb      (USER_WEb),
    .USER_REb      (USER_REb),
    .USER_OEb      (USER_OEb)
  );

  assign SEQ_BUSY   = (state_q != S_IDLE);
  assign SEQ_DONE   = (state_q == S_DONE);
  assign SEQ_ERROR  = err_q;
  assign CUR_CONFIG = cfg_q;

endmodule
